// File: rtl/pulse_generator.sv
// pulse_generator: multi-channel fixed-width pulse generator with guard gap.
// Each channel turns one-cycle requests into registered pulses of PULSE_LEN
// cycles, followed by at least GAP_LEN inactive cycles.
// Ports:
//   clk           - clock, rising edge
//   rst           - asynchronous reset, active low
//   trigger_input - per-channel pulse request, sampled every edge
//   signal_output - per-channel registered pulse output
//   busy          - per-channel ACTIVE/GUARD/pending status
// Build option: define PULSE_GEN_RETRIGGER_EN so that a request during a
// pulse extends it instead of queueing a follow-up pulse.
module pulse_generator #(
    parameter int SIGNAL_NUM   = 8,
    parameter int PULSE_LEN    = 4,
    parameter int GAP_LEN      = 2,
    parameter bit ACTIVE_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SIGNAL_NUM-1:0] trigger_input,
    output logic [SIGNAL_NUM-1:0] signal_output,
    output logic [SIGNAL_NUM-1:0] busy
);

    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CW      = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] PULSE_CNT = CW'(PULSE_LEN);
    localparam logic [CW-1:0] GAP_CNT   = CW'(GAP_LEN);
    localparam logic [CW-1:0] ONE       = CW'(1);

`ifdef PULSE_GEN_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GUARD  = 2'd2
    } state_t;

    for (genvar i = 0; i < SIGNAL_NUM; i++) begin : g_ch
        state_t        state;
        state_t        state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          pend;
        logic          pend_nxt;
        logic          out_q;
        logic          out_nxt;
        logic          trig;

        assign trig = trigger_input[i];

        // State register; the output bit is a flop of its own so no
        // combinational path exists from trigger_input to signal_output.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state <= IDLE;
                cnt   <= '0;
                pend  <= 1'b0;
                out_q <= ~ACTIVE_LEVEL;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                pend  <= pend_nxt;
                out_q <= out_nxt;
            end
        end

        // Next-state logic. The counter holds the cycles left in the
        // current ACTIVE or GUARD phase, including the present one.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            pend_nxt  = pend;
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        state_nxt = ACTIVE;
                        cnt_nxt   = PULSE_CNT;
                    end
                end
                ACTIVE: begin
                    if (RETRIG && trig) begin
                        cnt_nxt = PULSE_CNT;
                    end else begin
                        if (trig) begin
                            pend_nxt = 1'b1;
                        end
                        if (cnt == ONE) begin
                            if (GAP_LEN != 0) begin
                                state_nxt = GUARD;
                                cnt_nxt   = GAP_CNT;
                            end else if (pend || trig) begin
                                // No guard: next pulse merges with this one.
                                cnt_nxt  = PULSE_CNT;
                                pend_nxt = pend & trig;
                            end else begin
                                state_nxt = IDLE;
                                cnt_nxt   = '0;
                            end
                        end else begin
                            cnt_nxt = cnt - ONE;
                        end
                    end
                end
                GUARD: begin
                    if (cnt == ONE) begin
                        if (pend || trig) begin
                            // A queued request is served first; a trigger
                            // arriving alongside it becomes the new pending.
                            state_nxt = ACTIVE;
                            cnt_nxt   = PULSE_CNT;
                            pend_nxt  = pend & trig;
                        end else begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        cnt_nxt = cnt - ONE;
                        if (trig) begin
                            pend_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    pend_nxt  = 1'b0;
                end
            endcase
        end

        // Output logic: the registered level follows the next state.
        always_comb begin
            out_nxt = ~ACTIVE_LEVEL;
            if (state_nxt == ACTIVE) begin
                out_nxt = ACTIVE_LEVEL;
            end
        end

        assign signal_output[i] = out_q;
        assign busy[i]          = (state != IDLE) | pend;
    end

endmodule

// File: tb/tb_pulse_generator.sv
// tb_pulse_generator: randomized and directed checks of pulse_generator
// against a time-based reference model of pulse start/end/ready edges.
module tb_pulse_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] trig_a = '0;
    logic [7:0] trig_b = '0;
    logic [7:0] sig_a;
    logic [7:0] busy_a;
    logic [7:0] sig_b;
    logic [7:0] busy_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

`ifdef PULSE_GEN_RETRIGGER_EN
    localparam bit RT = 1'b1;
`else
    localparam bit RT = 1'b0;
`endif

    // DUT a: active-high, PULSE_LEN 3, GAP_LEN 2
    pulse_generator #(
        .SIGNAL_NUM(8), .PULSE_LEN(3), .GAP_LEN(2), .ACTIVE_LEVEL(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .trigger_input(trig_a),
        .signal_output(sig_a), .busy(busy_a)
    );

    // DUT b: active-low, PULSE_LEN 2, GAP_LEN 0
    pulse_generator #(
        .SIGNAL_NUM(8), .PULSE_LEN(2), .GAP_LEN(0), .ACTIVE_LEVEL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .trigger_input(trig_b),
        .signal_output(sig_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Model per channel: pulse start edge, end edge (exclusive), edge at
    // which the channel may start again, and the one-deep pending bit.
    int ms[2][8];
    int me[2][8];
    int mr[2][8];
    bit mp[2][8];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                ms[d][i] = 0;
                me[d][i] = 0;
                mr[d][i] = 0;
                mp[d][i] = 1'b0;
            end
        end
    endtask

    task automatic model_edge(input int d, input int pl, input int gap,
                              input logic [7:0] t);
        for (int i = 0; i < 8; i++) begin
            if (cyc >= mr[d][i]) begin
                if (mp[d][i] || t[i]) begin
                    ms[d][i] = cyc;
                    me[d][i] = cyc + pl;
                    mr[d][i] = cyc + pl + gap;
                    mp[d][i] = mp[d][i] && t[i];
                end
            end else if (RT && cyc > ms[d][i] && cyc <= me[d][i]) begin
                if (t[i]) begin
                    me[d][i] = cyc + pl;
                    mr[d][i] = cyc + pl + gap;
                end
            end else if (t[i]) begin
                mp[d][i] = 1'b1;
            end
        end
    endtask

    function automatic logic [7:0] exp_sig(input int d, input logic al);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            v[i] = (cyc >= ms[d][i] && cyc < me[d][i]) ? al : ~al;
        end
        return v;
    endfunction

    function automatic logic [7:0] exp_busy(input int d);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            v[i] = (cyc < mr[d][i]) || mp[d][i];
        end
        return v;
    endfunction

    // Drive triggers, advance one edge, update model, settle past the edge.
    task automatic step(input logic [7:0] ta, input logic [7:0] tb);
        trig_a = ta;
        trig_b = tb;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            model_reset();
        end else begin
            model_edge(0, 3, 2, ta);
            model_edge(1, 2, 0, tb);
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(8'h00, 8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (6) begin
            step(8'($urandom), 8'($urandom));
            checks++;
            if (sig_b !== 8'hFF) begin
                errors++;
                $display("FAIL reset_sig_b got %h want ff", sig_b);
            end
            checks++;
            if (sig_a !== 8'h00) begin
                errors++;
                $display("FAIL reset_sig_a got %h want 00", sig_a);
            end
            checks++;
            if ((busy_a | busy_b) !== 8'h00) begin
                errors++;
                $display("FAIL reset_busy got %h/%h want 00",
                         busy_a, busy_b);
            end
        end
        rst = 1'b1;
        step(8'h01, 8'h01);
        checks++;
        if (sig_a !== 8'h01 || busy_a !== 8'h01) begin
            errors++;
            $display("FAIL first_trig_a got %h/%h want 01/01", sig_a, busy_a);
        end
        checks++;
        if (sig_b !== 8'hFE || busy_b !== 8'h01) begin
            errors++;
            $display("FAIL first_trig_b got %h/%h want fe/01", sig_b, busy_b);
        end
    endtask

    task automatic test_single_pulse();
        idle(6);
        for (int k = 0; k < 8; k++) begin
            step((k == 0) ? 8'h08 : 8'h00, 8'h00);
            checks++;
            if (sig_a[3] !== (k < 3) || busy_a[3] !== (k < 5)) begin
                errors++;
                $display("FAIL single k=%0d got out=%b busy=%b want %b %b",
                         k, sig_a[3], busy_a[3], k < 3, k < 5);
            end
            checks++;
            if (sig_a !== exp_sig(0, 1'b1)) begin
                errors++;
                $display("FAIL single_vec k=%0d got %h want %h",
                         k, sig_a, exp_sig(0, 1'b1));
            end
        end
    endtask

    task automatic test_active_trigger();
        logic t;
        logic want;
        idle(6);
        for (int k = 0; k < 12; k++) begin
            if (RT) begin
                t    = (k == 0 || k == 2);
                want = (k < 5);
            end else begin
                t    = (k <= 2);
                want = (k < 3) || (k >= 5 && k < 8);
            end
            step({7'b0, t}, 8'h00);
            checks++;
            if (sig_a[0] !== want) begin
                errors++;
                $display("FAIL active_trig k=%0d got %b want %b",
                         k, sig_a[0], want);
            end
            checks++;
            if (busy_a !== exp_busy(0)) begin
                errors++;
                $display("FAIL active_busy k=%0d got %h want %h",
                         k, busy_a, exp_busy(0));
            end
        end
    endtask

    task automatic test_gap0_merge();
        logic [7:0] tb;
        idle(6);
        for (int k = 0; k < 10; k++) begin
            tb    = 8'($urandom) & 8'hFE;
            tb[0] = (k == 0 || k == 2 || k == 4);
            step(8'h00, tb);
            checks++;
            if (sig_b[0] !== (k >= 6)) begin
                errors++;
                $display("FAIL gap0_merge k=%0d got %b want %b",
                         k, sig_b[0], k >= 6);
            end
            checks++;
            if (sig_b !== exp_sig(1, 1'b0) || busy_b !== exp_busy(1)) begin
                errors++;
                $display("FAIL gap0_vec k=%0d got %h/%h want %h/%h", k,
                         sig_b, busy_b, exp_sig(1, 1'b0), exp_busy(1));
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step(8'($urandom & $urandom), 8'($urandom & $urandom));
            checks++;
            if (sig_a !== exp_sig(0, 1'b1) || busy_a !== exp_busy(0)) begin
                errors++;
                $display("FAIL rand_a cyc=%0d got %h/%h want %h/%h", cyc,
                         sig_a, busy_a, exp_sig(0, 1'b1), exp_busy(0));
            end
            checks++;
            if (sig_b !== exp_sig(1, 1'b0) || busy_b !== exp_busy(1)) begin
                errors++;
                $display("FAIL rand_b cyc=%0d got %h/%h want %h/%h", cyc,
                         sig_b, busy_b, exp_sig(1, 1'b0), exp_busy(1));
            end
        end
    endtask

    task automatic test_reset_mid();
        idle(6);
        step(8'h01, 8'h01);
        step(8'h00, 8'h00);
        rst = 1'b0;
        #1;
        checks++;
        if (sig_a !== 8'h00 || sig_b !== 8'hFF) begin
            errors++;
            $display("FAIL reset_mid_async got %h/%h want 00/ff",
                     sig_a, sig_b);
        end
        checks++;
        if ((busy_a | busy_b) !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_busy got %h/%h want 00/00",
                     busy_a, busy_b);
        end
        idle(2);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step((k == 0) ? 8'h01 : 8'h00, 8'h00);
            checks++;
            if (sig_a[0] !== (k < 3)) begin
                errors++;
                $display("FAIL reset_mid_pulse k=%0d got %b want %b",
                         k, sig_a[0], k < 3);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_pulse();
        test_active_trigger();
        test_gap0_merge();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_generator.md
# pulse_generator

Multi-channel pulse generator: the output-side counterpart of the edge detector. The edge detector turns level transitions into one-cycle event pulses. This block turns one-cycle event requests into timed output pulses of fixed width, with a guaranteed inactive gap between pulses. It sits on the output side of the associative buffer, driving strobes and handshake lines whose width is set by parameter.

## Interface
- SIGNAL_NUM, 8: number of independent channels.
- PULSE_LEN, 4: active width of each output pulse in clock cycles; must be at least 1.
- GAP_LEN, 2: minimum inactive cycles after each pulse before the next pulse may start; 0 is allowed.
- ACTIVE_LEVEL, 1: output level during a pulse; 1 means active-high, 0 means active-low. Applies to all channels.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when low).
- trigger_input  input  SIGNAL_NUM  per-channel pulse request; sampled on each rising clk edge.
- signal_output  output  SIGNAL_NUM  per-channel registered pulse output.
- busy  output  SIGNAL_NUM  per-channel status; 1 while the channel is ACTIVE, in GUARD, or holding a pending request.

## Operation
- Each channel is an independent FSM with states IDLE, ACTIVE and GUARD. Each channel also has a down-counter and a one-deep pending flag.
- Counter width is clog2(max(PULSE_LEN, GAP_LEN) + 1).
- IDLE:
  - Trigger sampled high: load counter with PULSE_LEN and go to ACTIVE.
  - Trigger sampled low: stay in IDLE.
- ACTIVE:
  - signal_output is at ACTIVE_LEVEL; the counter decrements each cycle.
  - On the last active cycle (counter = 1): go to GUARD with counter = GAP_LEN.
  - If GAP_LEN = 0, apply the GUARD-exit rule below instead.
- GUARD:
  - signal_output is at the inactive level (~ACTIVE_LEVEL); the counter decrements each cycle.
  - GUARD-exit rule, on the last guard cycle: if pending or trigger is sampled high, go to ACTIVE with counter = PULSE_LEN and clear pending. Otherwise go to IDLE.
- Pending flag:
  - Set by a trigger sampled in GUARD that is not consumed by the GUARD-exit rule.
  - Without the retrigger macro, also set by a trigger sampled in ACTIVE.
  - Never counts beyond one; extra requests are dropped.
  - Cleared only when its pulse starts.
- busy = (state != IDLE) | pending.
- signal_output is driven directly from a flip-flop: no combinational path from trigger_input.
- Channels share nothing except clk and rst.

## Timing
- A trigger high in the cycle before rising edge k, sampled by a channel in IDLE, makes signal_output active from edge k.
- The output stays active for exactly PULSE_LEN cycles and returns to inactive at edge k + PULSE_LEN.
- Minimum pulse period is PULSE_LEN + GAP_LEN cycles.
- A pending request starts its pulse at the edge that ends GUARD, giving back-to-back pulses separated by exactly GAP_LEN inactive cycles.
- Boundary cases:
  - With GAP_LEN = 0, pending or trigger on the last active cycle gives a continuous active level: two pulses merge.
  - A trigger coinciding with the GUARD-exit edge is consumed directly and does not set pending.
- Reset values, while rst = 0 and regardless of clk:
  - every channel in IDLE, counter 0, pending 0;
  - signal_output = {SIGNAL_NUM{~ACTIVE_LEVEL}};
  - busy = 0.
- Reset asserted mid-pulse aborts the pulse immediately. The first trigger sampled after rst deasserts is honoured normally.

## Configuration
- PULSE_GEN_RETRIGGER_EN defined:
  - a trigger sampled in ACTIVE reloads the counter with PULSE_LEN, extending the current pulse so it ends PULSE_LEN cycles after the last such trigger;
  - it does not set pending.
- PULSE_GEN_RETRIGGER_EN undefined:
  - a trigger sampled in ACTIVE sets pending;
  - the pulse width is never extended.
- Triggers sampled in GUARD behave identically in both builds.

## Test plan
- Reset: hold rst = 0 with ACTIVE_LEVEL = 0 and triggers toggling -> signal_output = 8'hFF and busy = 0 throughout. Release rst, then a single trigger on ch0 -> pulse starts the next edge.
- Single pulse (PULSE_LEN = 3, GAP_LEN = 2): one-cycle trigger on ch3 sampled at edge 10 -> signal_output[3] high at edges 10–12, low from 13. busy[3] high from 10 through 14, low from 15.
- Pending, macro undefined: ch0 triggers sampled at edges 10 and 11 -> pulses at 10–12 and 15–17 (gap exactly 2). A third trigger at 12 is dropped.
- Retrigger, macro defined: ch0 triggers sampled at edges 10 and 12 -> one pulse 10–14, then GUARD; no second pulse.
- GAP_LEN = 0 with triggers on consecutive pulse ends -> continuous high with no glitch. Meanwhile independent stimulus on ch1–ch7 has no cross-channel effect.
- Reset mid-pulse: rst asserted at edge 11 of a pulse started at 10 -> output inactive immediately, without waiting for an edge. After release, a new trigger yields a full 3-cycle pulse.
